// File: rtl/fibonacci_checker.sv
// Sink-side checker for a single- or double-rate Fibonacci stream.
// It tracks the expected sequence, flags mismatches and keeps first-error diagnostics.
module fibonacci_checker #(
    parameter int WIDTH         = 16,
    parameter int CNT_W         = 16,
    parameter bit STOP_ON_ERROR = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_num,
    input  logic [WIDTH-1:0] in_num2,
    input  logic             in_pair,
    output logic             match_valid,
    output logic             match,
    output logic [CNT_W-1:0] count,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] err_index,
    output logic [WIDTH-1:0] err_expected,
    output logic [WIDTH-1:0] err_got
);

    typedef enum logic {ST_RUN, ST_ERR} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] exp_a_q, exp_a_d;
    logic [WIDTH-1:0] exp_b_q, exp_b_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] err_index_q, err_index_d;
    logic [WIDTH-1:0] err_expected_q, err_expected_d;
    logic [WIDTH-1:0] err_got_q, err_got_d;
    logic             match_valid_q, match_valid_d;
    logic             match_q, match_d;

    logic             accept;
    logic             lane0_bad;
    logic             lane1_bad;
    logic             beat_bad;
    logic [1:0]       bad_lanes;
    logic [WIDTH-1:0] sum_ab;
    logic [WIDTH-1:0] sum_abb;

    // Saturating add of a small step; anything past all-ones clamps there.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:  if (accept && beat_bad) state_d = ST_ERR;
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        in_ready = !clear && !(STOP_ON_ERROR && (state_q == ST_ERR));
        err      = (state_q == ST_ERR);
    end

    assign accept    = in_valid && in_ready;
    assign lane0_bad = (in_num != exp_a_q);
    assign lane1_bad = in_pair && (in_num2 != exp_b_q);
    assign beat_bad  = lane0_bad || lane1_bad;
    assign bad_lanes = {1'b0, lane0_bad} + {1'b0, lane1_bad};
    assign sum_ab    = exp_a_q + exp_b_q;
    assign sum_abb   = sum_ab + exp_b_q;

    // The expected sequence always advances from its own values, never from received data.
    always_comb begin
        exp_a_d        = exp_a_q;
        exp_b_d        = exp_b_q;
        count_d        = count_q;
        err_count_d    = err_count_q;
        err_index_d    = err_index_q;
        err_expected_d = err_expected_q;
        err_got_d      = err_got_q;
        match_valid_d  = 1'b0;
        match_d        = 1'b0;
        if (clear) begin
            exp_a_d        = {{(WIDTH-1){1'b0}}, 1'b1};
            exp_b_d        = {{(WIDTH-1){1'b0}}, 1'b1};
            count_d        = '0;
            err_count_d    = '0;
            err_index_d    = '0;
            err_expected_d = '0;
            err_got_d      = '0;
        end else if (accept) begin
            match_valid_d = 1'b1;
            match_d       = !beat_bad;
            err_count_d   = sat_add(err_count_q, bad_lanes);
            if (in_pair) begin
                exp_a_d = sum_ab;
                exp_b_d = sum_abb;
                count_d = sat_add(count_q, 2'd2);
            end else begin
                exp_a_d = exp_b_q;
                exp_b_d = sum_ab;
                count_d = sat_add(count_q, 2'd1);
            end
            if ((state_q == ST_RUN) && beat_bad) begin
                if (lane0_bad) begin
                    err_index_d    = count_q;
                    err_expected_d = exp_a_q;
                    err_got_d      = in_num;
                end else begin
                    err_index_d    = sat_add(count_q, 2'd1);
                    err_expected_d = exp_b_q;
                    err_got_d      = in_num2;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_a_q        <= {{(WIDTH-1){1'b0}}, 1'b1};
            exp_b_q        <= {{(WIDTH-1){1'b0}}, 1'b1};
            count_q        <= '0;
            err_count_q    <= '0;
            err_index_q    <= '0;
            err_expected_q <= '0;
            err_got_q      <= '0;
            match_valid_q  <= 1'b0;
            match_q        <= 1'b0;
        end else begin
            exp_a_q        <= exp_a_d;
            exp_b_q        <= exp_b_d;
            count_q        <= count_d;
            err_count_q    <= err_count_d;
            err_index_q    <= err_index_d;
            err_expected_q <= err_expected_d;
            err_got_q      <= err_got_d;
            match_valid_q  <= match_valid_d;
            match_q        <= match_d;
        end
    end

    assign match_valid  = match_valid_q;
    assign match        = match_q;
    assign count        = count_q;
    assign err_count    = err_count_q;
    assign err_index    = err_index_q;
    assign err_expected = err_expected_q;
    assign err_got      = err_got_q;

endmodule

// File: doc/fibonacci_checker.md
Name: fibonacci_checker

Overview:
Consumer-side checker for the Fibonacci generator stream, single-rate or double-rate. It accepts beats of one or two numbers over a valid/ready handshake and compares each number against an internally tracked expected sequence 1, 1, 2, 3, 5, … modulo 2^WIDTH. It reports per-beat match status, a count of accepted numbers, and sticky first-error diagnostics. It sits at the sink end of generator test harnesses and on-chip self-test paths.

Parameters:
WIDTH, 16, data width; expected sequence wraps modulo 2^WIDTH, matching generator truncation
CNT_W, 16, width of count, err_count and err_index
STOP_ON_ERROR, 1, 1: stop accepting beats after the first mismatch; 0: keep checking

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
clear  input  1  synchronous restart to reset state; priority over everything except rst
in_valid  input  1  beat present
in_ready  output  1  checker accepts beat this cycle
in_num  input  WIDTH  lane 0, earlier number of the beat
in_num2  input  WIDTH  lane 1, later number; used only when in_pair=1
in_pair  input  1  1: beat carries two numbers; 0: lane 0 only
match_valid  output  1  one-cycle pulse, one cycle after each accepted beat
match  output  1  all lanes of that beat correct; qualified by match_valid
count  output  CNT_W  total numbers accepted; saturates at all-ones
err  output  1  sticky; set on the first mismatch
err_count  output  CNT_W  mismatching numbers; saturating
err_index  output  CNT_W  0-based sequence index of the first mismatching number
err_expected  output  WIDTH  expected value at the first mismatch
err_got  output  WIDTH  received value at the first mismatch

Behaviour:
- Reset (rst=0, async) and clear=1 (sync) give the same state.
  - exp_a=1, exp_b=1, state RUN.
  - count, err_count, err_index, err_expected and err_got are 0.
  - err, match_valid and match are 0.
- Handshake: a beat is accepted when in_valid && in_ready.
  - in_ready=0 while clear=1.
  - in_ready=0 in state ERR when STOP_ON_ERROR=1.
  - in_ready=1 otherwise. It is combinational from state and clear.
- Single beat (in_pair=0):
  - Compare in_num with exp_a.
  - Update {exp_a, exp_b} <= {exp_b, exp_a+exp_b}.
  - count += 1.
- Pair beat (in_pair=1):
  - Compare in_num with exp_a and in_num2 with exp_b.
  - Update {exp_a, exp_b} <= {exp_a+exp_b, exp_a+2*exp_b}.
  - count += 2.
- All sums truncate to WIDTH bits. count and err_count saturate; a +2 step that would exceed all-ones clamps to all-ones.
- match_valid/match are registered, latency 1 cycle from acceptance. No pulse is produced for unaccepted cycles.
- States:
  - RUN -> ERR on the first accepted beat with any mismatch.
  - ERR -> RUN only via clear or rst.
- First-error capture:
  - Taken only on the RUN->ERR transition.
  - If lane 0 mismatches, it is recorded: err_index=count, err_expected=exp_a, err_got=in_num.
  - Otherwise lane 1 is recorded: err_index=count+1 (saturating), err_expected=exp_b, err_got=in_num2.
  - err goes to 1 in the same cycle match_valid pulses with match=0.
- err_count adds the number of mismatching lanes in every accepted beat, in both RUN and ERR.
- ERR with STOP_ON_ERROR=0:
  - Beats are still accepted and compared.
  - The expected sequence advances from the expected values, not the received ones (no resync).
  - The first-error fields are frozen.
- Simultaneous clear and in_valid: the beat is not accepted, and no match_valid pulse follows.
- rst asserted mid-operation clears all state immediately, including a pending match_valid.

Test Plan:
1. Reset, then 10 single beats 1,1,2,3,5,8,13,21,34,55 -> 10 match pulses all match=1; count=10; err=0; err_count=0.
2. Five pair beats (1,1),(2,3),(5,8),(13,21),(34,55), one per cycle -> 5 match pulses, match=1; count=10; in_ready stays 1.
3. Mixed beats: single 1, pair (1,2), single 3, pair (5,8), plus in_valid gaps -> all match=1; count=6; no pulses in gap cycles.
4. Beats 1,1,2,3 single, then pair (5,9), STOP_ON_ERROR=1 -> match=0 on that beat; err=1; err_index=5, err_expected=8, err_got=9; err_count=1; in_ready=0 from the next cycle.
5. Same stimulus with STOP_ON_ERROR=0, then single 13 and single 99 -> 13 gives match=1; 99 gives match=0; err_count=2; first-error fields unchanged (index 5).
6. Wrap, WIDTH=16: feed 25 correct numbers; index 23=46368, index 24=75025 mod 65536=9489 -> match=1; then clear, followed by single 1 -> count=1, err=0. Pulse rst low mid-ERR -> all outputs 0 immediately.
